press_decoder: RTL and testbench

- Consumer side of the debounced button interface: turns a clean debounced level into single-cycle user events: press, short release, long press, auto-repeat.
- Sits between each debouncer output and the dice control FSM, clocked by the same slow clk and the same ms-scale tick strobe.
- Gives the control logic ready-made gestures: tap to roll, hold to select, hold longer to scroll.

---
 rtl/press_decoder.sv | 129 ++++++++++++
 tb/tb_press_decoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/press_decoder.sv
// Turns a debounced button level into single-cycle gesture events:
// press, short release, long press and auto-repeat, all on registered outputs.
module press_decoder #(
    parameter int LONG_TICKS         = 64,
    parameter int REPEAT_DELAY_TICKS = 32,
    parameter int REPEAT_TICKS       = 8,
    parameter int CNT_W              = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       debounced,
    output logic       press_pulse,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       release_pulse,
    output logic       held,
    output logic [7:0] repeat_count
);

    typedef enum logic [1:0] {IDLE, HELD, LONG, REPEAT} state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             deb_q;
    logic [7:0]       rc_nxt, rc_inc;
    logic             press_nxt, short_nxt, long_nxt, repeat_nxt, release_nxt;

    assign rc_inc = (repeat_count == 8'hFF) ? repeat_count : repeat_count + 8'd1;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        rc_nxt      = repeat_count;
        press_nxt   = 1'b0;
        short_nxt   = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        release_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (debounced && !deb_q) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    rc_nxt    = 8'd0;
                    press_nxt = 1'b1;
                end
            end
            // Release wins over a coincident tick in every held state.
            HELD: begin
                if (!debounced) begin
                    state_nxt   = IDLE;
                    short_nxt   = 1'b1;
                    release_nxt = 1'b1;
                end else if (tick) begin
                    if (cnt == LONG_LAST) begin
                        state_nxt = LONG;
                        cnt_nxt   = '0;
                        long_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            LONG: begin
                if (!debounced) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                end else if (tick) begin
                    if (cnt == DELAY_LAST) begin
                        state_nxt  = REPEAT;
                        cnt_nxt    = '0;
                        repeat_nxt = 1'b1;
                        rc_nxt     = rc_inc;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            REPEAT: begin
                if (!debounced) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                end else if (tick) begin
                    if (cnt == REPEAT_LAST) begin
                        cnt_nxt    = '0;
                        repeat_nxt = 1'b1;
                        rc_nxt     = rc_inc;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // deb_q tracks the input even in reset so a button held through reset is not a press.
    always_ff @(posedge clk) begin
        deb_q <= debounced;
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            repeat_count  <= 8'd0;
            press_pulse   <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            held          <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            repeat_count  <= rc_nxt;
            press_pulse   <= press_nxt;
            short_pulse   <= short_nxt;
            long_pulse    <= long_nxt;
            repeat_pulse  <= repeat_nxt;
            release_pulse <= release_nxt;
            held          <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_press_decoder.sv
// Bench for press_decoder: a default-parameter instance and a 1/1/1 instance
// share stimulus and are both checked against a tick-counting reference model.
module tb_press_decoder;

    logic clk = 1'b0;
    logic rst_n, tick, debounced;
    logic press0, short0, long0, rep0, rel0, held0;
    logic press1, short1, long1, rep1, rel1, held1;
    logic [7:0] rc0, rc1;

    int nchk = 0;
    int nerr = 0;
    int n_press0, n_short0, n_long0, n_rep0, n_rel0, n_rep1;

    always #5 clk = ~clk;

    press_decoder #(.LONG_TICKS(64), .REPEAT_DELAY_TICKS(32), .REPEAT_TICKS(8), .CNT_W(8)) d0 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .debounced(debounced),
        .press_pulse(press0), .short_pulse(short0), .long_pulse(long0),
        .repeat_pulse(rep0), .release_pulse(rel0), .held(held0), .repeat_count(rc0));

    press_decoder #(.LONG_TICKS(1), .REPEAT_DELAY_TICKS(1), .REPEAT_TICKS(1), .CNT_W(8)) d1 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .debounced(debounced),
        .press_pulse(press1), .short_pulse(short1), .long_pulse(long1),
        .repeat_pulse(rep1), .release_pulse(rel1), .held(held1), .repeat_count(rc1));

    // Model: count ticks since the press; events fall on fixed tick numbers.
    typedef struct {bit active; int ticks; int rc; bit prev;} mstate_t;
    typedef struct {bit press, shrt, lng, rpt, rel, held; int rc;} mout_t;

    mstate_t s0 = '{0, 0, 0, 1'b1};
    mstate_t s1 = '{0, 0, 0, 1'b1};
    mout_t   e0, e1;

    task automatic model_step(input int L, input int D, input int R, input bit r, input bit t,
                              input bit d, inout mstate_t s, output mout_t o);
        o = '{0, 0, 0, 0, 0, 0, 0};
        if (!r) begin
            s.active = 0; s.ticks = 0; s.rc = 0;
        end else if (!s.active) begin
            if (d && !s.prev) begin
                s.active = 1; s.ticks = 0; s.rc = 0; o.press = 1;
            end
        end else if (!d) begin
            o.rel = 1; o.shrt = (s.ticks < L); s.active = 0;
        end else if (t) begin
            s.ticks++;
            if (s.ticks == L) o.lng = 1;
            if (s.ticks >= L + D && ((s.ticks - L - D) % R) == 0) begin
                o.rpt = 1;
                if (s.rc < 255) s.rc++;
            end
        end
        s.prev = d;
        o.held = s.active;
        o.rc   = s.rc;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit t, input bit d);
        rst_n = r; tick = t; debounced = d;
        @(posedge clk);
        model_step(64, 32, 8, r, t, d, s0, e0);
        model_step(1, 1, 1, r, t, d, s1, e1);
        #1;
        chk("d0.press",   int'(press0), int'(e0.press));
        chk("d0.short",   int'(short0), int'(e0.shrt));
        chk("d0.long",    int'(long0),  int'(e0.lng));
        chk("d0.repeat",  int'(rep0),   int'(e0.rpt));
        chk("d0.release", int'(rel0),   int'(e0.rel));
        chk("d0.held",    int'(held0),  int'(e0.held));
        chk("d0.rc",      int'(rc0),    e0.rc);
        chk("d1.press",   int'(press1), int'(e1.press));
        chk("d1.short",   int'(short1), int'(e1.shrt));
        chk("d1.long",    int'(long1),  int'(e1.lng));
        chk("d1.repeat",  int'(rep1),   int'(e1.rpt));
        chk("d1.release", int'(rel1),   int'(e1.rel));
        chk("d1.held",    int'(held1),  int'(e1.held));
        chk("d1.rc",      int'(rc1),    e1.rc);
        n_press0 += int'(press0); n_short0 += int'(short0); n_long0 += int'(long0);
        n_rep0   += int'(rep0);   n_rel0   += int'(rel0);   n_rep1  += int'(rep1);
    endtask

    task automatic clr_counts();
        n_press0 = 0; n_short0 = 0; n_long0 = 0; n_rep0 = 0; n_rel0 = 0; n_rep1 = 0;
    endtask

    typedef struct {bit r, t, d; bit press, shrt, rel, held;} vec_t;
    vec_t tbl[15];

    initial begin
        rst_n = 1'b0; tick = 1'b0; debounced = 1'b0;
        clr_counts();
        // Expected outputs are those visible just after the edge that samples the inputs.
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 1, 1, 0, 0, 1};  // press with coincident tick
        tbl[3]  = '{1, 1, 1, 0, 0, 0, 1};
        tbl[4]  = '{1, 0, 1, 0, 0, 0, 1};
        tbl[5]  = '{1, 1, 0, 0, 1, 1, 0};  // release beats tick
        tbl[6]  = '{1, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 0, 1, 1, 0, 0, 1};
        tbl[8]  = '{1, 0, 0, 0, 1, 1, 0};
        tbl[9]  = '{1, 0, 1, 1, 0, 0, 1};  // re-press after one idle cycle
        tbl[10] = '{1, 0, 1, 0, 0, 0, 1};
        tbl[11] = '{0, 0, 1, 0, 0, 0, 0};  // reset while held
        tbl[12] = '{1, 0, 1, 0, 0, 0, 0};  // held through reset: no press
        tbl[13] = '{1, 0, 0, 0, 0, 0, 0};
        tbl[14] = '{1, 0, 1, 1, 0, 0, 1};

        cyc(0, 0, 0);
        cyc(0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].r, tbl[i].t, tbl[i].d);
            chk($sformatf("tbl[%0d].press", i),   int'(press0), int'(tbl[i].press));
            chk($sformatf("tbl[%0d].short", i),   int'(short0), int'(tbl[i].shrt));
            chk($sformatf("tbl[%0d].release", i), int'(rel0),   int'(tbl[i].rel));
            chk($sformatf("tbl[%0d].held", i),    int'(held0),  int'(tbl[i].held));
        end
        cyc(1, 0, 0);
        cyc(1, 0, 0);

        // Short tap of 10 ticks.
        clr_counts();
        cyc(1, 0, 1);
        chk("tap.press", int'(press0), 1);
        for (int i = 0; i < 10; i++) begin cyc(1, 1, 1); cyc(1, 0, 1); end
        chk("tap.held", int'(held0), 1);
        cyc(1, 0, 0);
        chk("tap.short", int'(short0), 1);
        chk("tap.release", int'(rel0), 1);
        cyc(1, 0, 0);
        chk("tap.n_long", n_long0, 0);
        chk("tap.n_rep", n_rep0, 0);
        chk("tap.n_press", n_press0, 1);

        // Long hold of 130 ticks.
        clr_counts();
        cyc(1, 0, 1);
        for (int i = 0; i < 130; i++) begin cyc(1, 1, 1); cyc(1, 0, 1); cyc(1, 0, 1); end
        chk("long.n_long", n_long0, 1);
        chk("long.n_rep", n_rep0, 5);
        chk("long.rc", int'(rc0), 5);
        cyc(1, 0, 0);
        chk("long.release", int'(rel0), 1);
        chk("long.short", int'(short0), 0);
        cyc(1, 0, 0);
        chk("long.rc_kept", int'(rc0), 5);

        // Release coinciding with tick 64.
        clr_counts();
        cyc(1, 0, 1);
        for (int i = 0; i < 63; i++) cyc(1, 1, 1);
        cyc(1, 1, 0);
        chk("race.short", int'(short0), 1);
        chk("race.held", int'(held0), 0);
        cyc(1, 0, 0);
        chk("race.n_long", n_long0, 0);

        // Reset after three repeats, button still held.
        clr_counts();
        cyc(1, 0, 1);
        for (int i = 0; i < 112; i++) cyc(1, 1, 1);
        chk("mid.n_rep", n_rep0, 3);
        cyc(0, 0, 1);
        chk("mid.any_pulse", int'({press0, short0, long0, rep0, rel0}), 0);
        chk("mid.held", int'(held0), 0);
        chk("mid.rc", int'(rc0), 0);
        clr_counts();
        for (int i = 0; i < 40; i++) cyc(1, 1, 1);
        chk("mid.after_rep", n_rep0, 0);
        chk("mid.after_press", n_press0, 0);
        chk("mid.after_held", int'(held0), 0);

        // Saturation on the 1/1/1 instance.
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 1);
        clr_counts();
        for (int i = 0; i < 300; i++) cyc(1, 1, 1);
        chk("sat.n_rep", n_rep1, 299);
        chk("sat.rc", int'(rc1), 255);
        chk("sat.last_rep", int'(rep1), 1);
        cyc(1, 0, 0);
        cyc(1, 0, 0);

        // Random long-ish holds with random ticks.
        begin
            bit d = 1'b0;
            for (int i = 0; i < 6000; i++) begin
                if ($urandom_range(0, 299) == 0) d = ~d;
                cyc(($urandom_range(0, 999) != 0), $urandom_range(0, 1) == 1, d);
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
